// File: rtl/y86_imem_loader.sv
// Byte-serial program loader and instruction memory with a 10-byte fetch window.
// Define IMEM_CHECKSUM_EN to add a running 8-bit checksum of loaded bytes.
module y86_imem_loader #(
    parameter int MEM_BYTES = 1024,
    parameter int ADDR_W    = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ld_start_i,
    input  logic [ADDR_W-1:0] ld_base_i,
    input  logic              ld_valid_i,
    input  logic [7:0]        ld_byte_i,
    input  logic              ld_last_i,
    output logic              ld_ready_o,
    output logic [ADDR_W:0]   load_cnt_o,
    output logic              load_ovf_o,
    output logic              cpu_run_o,
    input  logic [63:0]       f_pc_i,
    output logic [79:0]       f_Byte_o,
    output logic              imem_error_o,
    output logic [7:0]        ld_csum_o
);

    localparam logic [ADDR_W:0] FULL    = (ADDR_W+1)'(MEM_BYTES);
    localparam logic [63:0]     LAST_PC = 64'(MEM_BYTES - 10);
    localparam logic [64:0]     MEM_END = 65'(MEM_BYTES);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              clear;
    logic              accept;
    logic [7:0]        mem_q [MEM_BYTES];
    logic [64:0]       fa;

    // Ready depends only on registered state, never on ld_valid_i.
    assign ld_ready_o = (state_q == LOAD) && (cnt_q < FULL);
    assign accept     = ld_ready_o && ld_valid_i;
    assign load_cnt_o = cnt_q;
    assign load_ovf_o = ovf_q;
    assign cpu_run_o  = (state_q == RUN);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        clear   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ld_start_i) begin
                    state_d = LOAD;
                    clear   = 1'b1;
                end
            end
            LOAD: begin
                if (accept) begin
                    addr_d = addr_q + 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    if (ld_last_i) state_d = RUN;
                end else if (cnt_q == FULL) begin
                    ovf_d   = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (ld_start_i) begin
                    state_d = LOAD;
                    clear   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (clear) begin
            addr_d = ld_base_i;
            cnt_d  = '0;
            ovf_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < MEM_BYTES; i++) mem_q[i] <= 8'h00;
        end else if (accept) begin
            mem_q[addr_q] <= ld_byte_i;
        end
    end

    // 65-bit sum so a window near 2^64 cannot wrap back into range.
    always_comb begin
        f_Byte_o = '0;
        fa       = '0;
        for (int k = 0; k < 10; k++) begin
            fa = {1'b0, f_pc_i} + 65'(k);
            if (fa < MEM_END) f_Byte_o[79-8*k -: 8] = mem_q[fa[ADDR_W-1:0]];
        end
    end

    assign imem_error_o = (f_pc_i > LAST_PC);

`ifdef IMEM_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (clear) csum_d = 8'h00;
        else if (accept) csum_d = csum_q + ld_byte_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) csum_q <= 8'h00;
        else csum_q <= csum_d;
    end

    assign ld_csum_o = csum_q;
`else
    assign ld_csum_o = 8'h00;
`endif

endmodule

// File: tb/tb_y86_imem_loader.sv
// Randomized self-checking bench for y86_imem_loader against a
// byte-array model of the loader and fetch window.
module tb_y86_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_start;
    logic [9:0]  ld_base;
    logic        ld_valid;
    logic [7:0]  ld_byte;
    logic        ld_last;
    logic        ld_ready;
    logic [10:0] load_cnt;
    logic        load_ovf;
    logic        cpu_run;
    logic [63:0] f_pc;
    logic [79:0] f_Byte;
    logic        imem_error;
    logic [7:0]  ld_csum;

    int n_cmp  = 0;
    int n_fail = 0;

    byte unsigned m_mem [1024];
    bit           m_load, m_run, m_ovf;
    int           m_cnt, m_addr;
    byte unsigned m_csum;

    always #5 clk = ~clk;

    y86_imem_loader #(.MEM_BYTES(1024), .ADDR_W(10)) dut (
        .clk_i(clk), .rst_i(rst), .ld_start_i(ld_start), .ld_base_i(ld_base),
        .ld_valid_i(ld_valid), .ld_byte_i(ld_byte), .ld_last_i(ld_last),
        .ld_ready_o(ld_ready), .load_cnt_o(load_cnt), .load_ovf_o(load_ovf),
        .cpu_run_o(cpu_run), .f_pc_i(f_pc), .f_Byte_o(f_Byte),
        .imem_error_o(imem_error), .ld_csum_o(ld_csum)
    );

    function automatic logic [79:0] exp_win(input logic [63:0] pc);
        logic [79:0] w = '0;
        for (int k = 0; k < 10; k++)
            if (pc < 64'(1024 - k)) w[79-8*k -: 8] = m_mem[int'(pc) + k];
        return w;
    endfunction

    function automatic logic [7:0] exp_csum();
`ifdef IMEM_CHECKSUM_EN
        return m_csum;
`else
        return 8'h00;
`endif
    endfunction

    task automatic model_clear();
        foreach (m_mem[i]) m_mem[i] = 8'h00;
        m_load = 0; m_run = 0; m_ovf = 0;
        m_cnt = 0; m_addr = 0; m_csum = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
    endtask

    // One clock of stimulus; the model advances by the loader's rules.
    task automatic cyc(input bit st, input int base, input bit v,
                       input logic [7:0] b, input bit last);
        ld_start = st; ld_base = 10'(base);
        ld_valid = v; ld_byte = b; ld_last = last;
        if (m_load) begin
            if (v && m_cnt < 1024) begin
                m_mem[m_addr] = b;
                m_addr = (m_addr + 1) % 1024;
                m_cnt++;
                m_csum += b;
                if (last) begin m_load = 0; m_run = 1; end
            end else if (m_cnt == 1024) begin
                m_ovf = 1; m_load = 0; m_run = 1;
            end
        end else if (st) begin
            m_load = 1; m_run = 0; m_addr = base;
            m_cnt = 0; m_ovf = 0; m_csum = 0;
        end
        @(posedge clk); #1;
        ld_start = 0; ld_valid = 0; ld_last = 0;
    endtask

    task automatic test_reset();
        do_reset();
        f_pc = 64'd0; #1;
        n_cmp++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got %b want 0", ld_ready); end
        n_cmp++; if (load_cnt !== 11'd0) begin n_fail++; $display("FAIL rst_cnt got %0d want 0", load_cnt); end
        n_cmp++; if (load_ovf !== 1'b0) begin n_fail++; $display("FAIL rst_ovf got %b want 0", load_ovf); end
        n_cmp++; if (cpu_run !== 1'b0) begin n_fail++; $display("FAIL rst_run got %b want 0", cpu_run); end
        n_cmp++; if (ld_csum !== 8'h00) begin n_fail++; $display("FAIL rst_csum got %h want 00", ld_csum); end
        n_cmp++; if (f_Byte !== 80'h0) begin n_fail++; $display("FAIL rst_win got %h want 0", f_Byte); end
    endtask

    task automatic test_load();
        cyc(1, 0, 0, 8'h00, 0);
        n_cmp++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL t1_ready got %b want 1", ld_ready); end
        cyc(0, 0, 1, 8'h30, 0);
        cyc(0, 0, 1, 8'hF2, 0);
        n_cmp++; if (cpu_run !== 1'b0) begin n_fail++; $display("FAIL t1_run_early got %b want 0", cpu_run); end
        cyc(0, 0, 1, 8'h0A, 1);
        f_pc = 64'd0; #1;
        n_cmp++; if (cpu_run !== 1'b1) begin n_fail++; $display("FAIL t1_run got %b want 1", cpu_run); end
        n_cmp++; if (load_cnt !== 11'd3) begin n_fail++; $display("FAIL t1_cnt got %0d want 3", load_cnt); end
        n_cmp++; if (f_Byte !== 80'h30F20A00000000000000) begin n_fail++; $display("FAIL t1_win got %h want 30F20A00000000000000", f_Byte); end
        n_cmp++; if (imem_error !== 1'b0) begin n_fail++; $display("FAIL t1_err got %b want 0", imem_error); end
        n_cmp++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL t1_ready_run got %b want 0", ld_ready); end
    endtask

    task automatic test_gaps();
        logic [7:0] b0, b1;
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 8'($urandom), 1);
        f_pc = 64'd0; #1;
        n_cmp++; if (f_Byte !== exp_win(0)) begin n_fail++; $display("FAIL t2_runwr got %h want %h", f_Byte, exp_win(0)); end
        n_cmp++; if (load_cnt !== 11'd3) begin n_fail++; $display("FAIL t2_runcnt got %0d want 3", load_cnt); end
        b0 = 8'($urandom); b1 = 8'($urandom);
        cyc(1, 16, 0, 8'h00, 0);
        cyc(0, 0, 1, b0, 0);
        cyc(0, 0, 0, 8'($urandom), 1);
        n_cmp++; if (load_cnt !== 11'd1) begin n_fail++; $display("FAIL t2_gapcnt got %0d want 1", load_cnt); end
        cyc(0, 0, 1, b1, 1);
        f_pc = 64'd16; #1;
        n_cmp++; if (load_cnt !== 11'd2) begin n_fail++; $display("FAIL t2_cnt got %0d want 2", load_cnt); end
        n_cmp++; if (f_Byte[79:64] !== {b0, b1}) begin n_fail++; $display("FAIL t2_bytes got %h want %h", f_Byte[79:64], {b0, b1}); end
        n_cmp++; if (f_Byte !== exp_win(16)) begin n_fail++; $display("FAIL t2_win got %h want %h", f_Byte, exp_win(16)); end
        do_reset();
        cyc(0, 0, 1, 8'hAB, 1);
        f_pc = 64'd0; #1;
        n_cmp++; if (f_Byte !== 80'h0) begin n_fail++; $display("FAIL t2_idlewr got %h want 0", f_Byte); end
    endtask

    task automatic test_wrap();
        logic [7:0] b [4];
        foreach (b[i]) b[i] = 8'($urandom);
        cyc(1, 1022, 0, 8'h00, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, b[i], i == 3);
        f_pc = 64'd1014; #1;
        n_cmp++; if (f_Byte[15:0] !== {b[0], b[1]}) begin n_fail++; $display("FAIL t3_top got %h want %h", f_Byte[15:0], {b[0], b[1]}); end
        f_pc = 64'd0; #1;
        n_cmp++; if (f_Byte[79:64] !== {b[2], b[3]}) begin n_fail++; $display("FAIL t3_low got %h want %h", f_Byte[79:64], {b[2], b[3]}); end
        n_cmp++; if (cpu_run !== 1'b1) begin n_fail++; $display("FAIL t3_run got %b want 1", cpu_run); end
    endtask

    task automatic test_overflow();
        cyc(1, 0, 0, 8'h00, 0);
        for (int i = 0; i < 1024; i++) begin
            n_cmp++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL t4_ready%0d got %b want 1", i, ld_ready); end
            cyc(0, 0, 1, 8'($urandom), 0);
        end
        n_cmp++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL t4_full got %b want 0", ld_ready); end
        n_cmp++; if (load_cnt !== 11'd1024) begin n_fail++; $display("FAIL t4_cnt got %0d want 1024", load_cnt); end
        cyc(0, 0, 1, 8'h5A, 1);
        cyc(0, 0, 0, 8'h00, 0);
        n_cmp++; if (load_ovf !== 1'b1) begin n_fail++; $display("FAIL t4_ovf got %b want 1", load_ovf); end
        n_cmp++; if (cpu_run !== 1'b1) begin n_fail++; $display("FAIL t4_run got %b want 1", cpu_run); end
        n_cmp++; if (load_cnt !== 11'd1024) begin n_fail++; $display("FAIL t4_cnt2 got %0d want 1024", load_cnt); end
        for (int i = 0; i < 8; i++) begin
            f_pc = 64'($urandom_range(0, 1014)); #1;
            n_cmp++; if (f_Byte !== exp_win(f_pc)) begin n_fail++; $display("FAIL t4_win pc=%0d got %h want %h", f_pc, f_Byte, exp_win(f_pc)); end
        end
    endtask

    task automatic test_bounds();
        logic [63:0] pcs [4];
        pcs[0] = 64'd1014; pcs[1] = 64'd1015;
        pcs[2] = 64'h1_0000_0000; pcs[3] = 64'hFFFF_FFFF_FFFF_FFFF;
        foreach (pcs[i]) begin
            f_pc = pcs[i]; #1;
            n_cmp++; if (imem_error !== (pcs[i] >= 64'd1015)) begin n_fail++; $display("FAIL t5_err pc=%h got %b want %b", pcs[i], imem_error, pcs[i] >= 64'd1015); end
            n_cmp++; if (f_Byte !== exp_win(pcs[i])) begin n_fail++; $display("FAIL t5_win pc=%h got %h want %h", pcs[i], f_Byte, exp_win(pcs[i])); end
        end
        f_pc = 64'd1015; #1;
        n_cmp++; if (f_Byte[7:0] !== 8'h00) begin n_fail++; $display("FAIL t5_b9 got %h want 00", f_Byte[7:0]); end
    endtask

    task automatic test_reset_midload();
        cyc(1, 0, 0, 8'h00, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 8'($urandom_range(1, 255)), 0);
        do_reset();
        f_pc = 64'd0; #1;
        n_cmp++; if ({ld_ready, load_cnt, load_ovf, cpu_run, ld_csum} !== 22'h0) begin n_fail++; $display("FAIL t6_outs got %h want 0", {ld_ready, load_cnt, load_ovf, cpu_run, ld_csum}); end
        n_cmp++; if (f_Byte !== 80'h0) begin n_fail++; $display("FAIL t6_mem got %h want 0", f_Byte); end
        cyc(1, 0, 0, 8'h00, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 8'($urandom), i == 2);
        cyc(1, 4, 0, 8'h00, 0);
        n_cmp++; if (cpu_run !== 1'b0) begin n_fail++; $display("FAIL t6_reld got %b want 0", cpu_run); end
        for (int i = 0; i < 2; i++) cyc(0, 0, 1, 8'($urandom), i == 1);
        #1;
        n_cmp++; if (f_Byte !== exp_win(0)) begin n_fail++; $display("FAIL t6_win got %h want %h", f_Byte, exp_win(0)); end
        n_cmp++; if (cpu_run !== 1'b1) begin n_fail++; $display("FAIL t6_run got %b want 1", cpu_run); end
    endtask

    task automatic test_checksum();
        cyc(1, 100, 0, 8'h00, 0);
        cyc(0, 0, 1, 8'hFF, 0);
        cyc(0, 0, 1, 8'h02, 0);
        n_cmp++; if (ld_csum !== exp_csum()) begin n_fail++; $display("FAIL t7_mid got %h want %h", ld_csum, exp_csum()); end
        cyc(0, 0, 1, 8'h10, 1);
`ifdef IMEM_CHECKSUM_EN
        n_cmp++; if (ld_csum !== 8'h11) begin n_fail++; $display("FAIL t7_csum got %h want 11", ld_csum); end
`else
        n_cmp++; if (ld_csum !== 8'h00) begin n_fail++; $display("FAIL t7_csum got %h want 00", ld_csum); end
`endif
    endtask

    task automatic test_random();
        for (int l = 0; l < 6; l++) begin
            int len = $urandom_range(1, 40);
            int sent = 0;
            cyc(1, $urandom_range(0, 1023), 0, 8'h00, 0);
            while (sent < len) begin
                bit v = ($urandom_range(0, 3) != 0);
                cyc(0, 0, v, 8'($urandom), v && (sent == len - 1));
                if (v) sent++;
            end
            n_cmp++; if (load_cnt !== 11'(m_cnt)) begin n_fail++; $display("FAIL tr_cnt got %0d want %0d", load_cnt, m_cnt); end
            n_cmp++; if (ld_csum !== exp_csum()) begin n_fail++; $display("FAIL tr_csum got %h want %h", ld_csum, exp_csum()); end
            for (int i = 0; i < 5; i++) begin
                f_pc = 64'($urandom_range(0, 1023)); #1;
                n_cmp++; if (f_Byte !== exp_win(f_pc)) begin n_fail++; $display("FAIL tr_win pc=%0d got %h want %h", f_pc, f_Byte, exp_win(f_pc)); end
            end
        end
    endtask

    initial begin
        rst = 1'b1; ld_start = 0; ld_base = '0; ld_valid = 0;
        ld_byte = '0; ld_last = 0; f_pc = '0;
        model_clear();
        test_reset();
        test_load();
        test_gaps();
        test_wrap();
        test_overflow();
        test_bounds();
        test_reset_midload();
        test_checksum();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
